// File: rtl/game_palette_encoder.sv
// Nearest-colour encoder: maps a 12-bit RGB pixel to the index of the closest entry of the game's 8-entry palette.
// Optional macro GAME_PALETTE_ENCODER_EARLY_EXIT_EN stops the search at the first exact match.
module game_palette_encoder #(
    parameter int N_ENTRIES = 8,
    parameter int DIST_W    = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_red,
    input  logic [3:0]        in_green,
    input  logic [3:0]        in_blue,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        out_index,
    output logic [DIST_W-1:0] out_dist,
    output logic              out_exact
);

    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

    state_t             state;
    state_t             stateNext;
    logic [3:0]         pixRed;
    logic [3:0]         pixGreen;
    logic [3:0]         pixBlue;
    logic [2:0]         cnt;
    logic [2:0]         bestIdx;
    logic [DIST_W-1:0]  bestDist;
    logic [11:0]        entryRgb;
    logic [DIST_W-1:0]  curDist;
    logic [DIST_W-1:0]  selDist;
    logic [2:0]         selIdx;
    logic               better;
    logic               lastEntry;
    logic               finish;

    function automatic logic [11:0] palette_rgb(input logic [2:0] idx);
        logic [11:0] rgb;
        case (idx)
            3'd0:    rgb = 12'hEEE;
            3'd1:    rgb = 12'hCCB;
            3'd2:    rgb = 12'hA99;
            3'd3:    rgb = 12'h666;
            3'd4:    rgb = 12'hCBA;
            3'd5:    rgb = 12'hA99;
            3'd6:    rgb = 12'hBBA;
            default: rgb = 12'h887;
        endcase
        return rgb;
    endfunction

    function automatic logic [7:0] sq_diff(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] d;
        logic [7:0] dWide;
        d     = (a > b) ? (a - b) : (b - a);
        dWide = {4'b0000, d};
        return dWide * dWide;
    endfunction

    // Distance of the captured pixel to the entry under evaluation, and the running-best update.
    always_comb begin
        entryRgb  = palette_rgb(cnt);
        curDist   = DIST_W'(sq_diff(pixRed,   entryRgb[11:8]))
                  + DIST_W'(sq_diff(pixGreen, entryRgb[7:4]))
                  + DIST_W'(sq_diff(pixBlue,  entryRgb[3:0]));
        better    = (curDist < bestDist);
        selDist   = better ? curDist : bestDist;
        selIdx    = better ? cnt : bestIdx;
        lastEntry = (cnt == 3'(N_ENTRIES - 1));
`ifdef GAME_PALETTE_ENCODER_EARLY_EXIT_EN
        finish    = lastEntry || (curDist == '0);
`else
        finish    = lastEntry;
`endif
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (in_valid) stateNext = SEARCH;
            SEARCH:  if (finish) stateNext = DONE;
            DONE:    if (out_ready) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE) && !reset;
    assign out_valid = (state == DONE);

    // Results are latched on the final search cycle so they hold steady under backpressure.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            bestIdx   <= '0;
            bestDist  <= '1;
            pixRed    <= '0;
            pixGreen  <= '0;
            pixBlue   <= '0;
            out_index <= '0;
            out_dist  <= '0;
            out_exact <= 1'b0;
        end else begin
            state <= stateNext;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        pixRed   <= in_red;
                        pixGreen <= in_green;
                        pixBlue  <= in_blue;
                        bestDist <= '1;
                        bestIdx  <= '0;
                        cnt      <= '0;
                    end
                end
                SEARCH: begin
                    bestDist <= selDist;
                    bestIdx  <= selIdx;
                    if (finish) begin
                        out_index <= selIdx;
                        out_dist  <= selDist;
                        out_exact <= (selDist == '0);
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_game_palette_encoder.sv
// Directed self-checking bench for game_palette_encoder: exact/nearest matches, ties, backpressure, reset and streaming.
module tb_game_palette_encoder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_red = '0;
    logic [3:0] in_green = '0;
    logic [3:0] in_blue = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [2:0] out_index;
    logic [9:0] out_dist;
    logic       out_exact;

    int testsRun = 0;
    int testsFailed = 0;
    int cycleCount = 0;

`ifdef GAME_PALETTE_ENCODER_EARLY_EXIT_EN
    localparam int LAT_WHITE = 1;
    localparam int LAT_A99   = 3;
`else
    localparam int LAT_WHITE = 8;
    localparam int LAT_A99   = 8;
`endif

    game_palette_encoder dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_red    (in_red),
        .in_green  (in_green),
        .in_blue   (in_blue),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .out_dist  (out_dist),
        .out_exact (out_exact)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Presents one pixel and returns just after the accepting edge.
    task automatic send_pixel(input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
        int guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        in_red   = r;
        in_green = g;
        in_blue  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        testsRun++;
        if (in_ready !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready);
        end
        testsRun++;
        if ({out_valid, out_index, out_dist, out_exact} !== 15'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_outputs: got valid=%b idx=%0d dist=%0d exact=%b expected all 0",
                     out_valid, out_index, out_dist, out_exact);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        testsRun++;
        if (in_ready !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL reset_release_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_pixel(input string name, input logic [3:0] r, input logic [3:0] g,
                              input logic [3:0] b, input logic [2:0] expIdx,
                              input logic [9:0] expDist, input int expLat);
        int lat;
        out_ready = 1'b1;
        send_pixel(r, g, b);
        wait_result(lat);
        testsRun++;
        if (expLat >= 0 && lat !== expLat) begin
            testsFailed++;
            $display("[TB] FAIL %s_latency: got %0d expected %0d", name, lat, expLat);
        end
        testsRun++;
        if (out_index !== expIdx || out_dist !== expDist || out_exact !== (expDist == 10'd0)) begin
            testsFailed++;
            $display("[TB] FAIL %s_result: got idx=%0d dist=%0d exact=%b expected idx=%0d dist=%0d exact=%b",
                     name, out_index, out_dist, out_exact, expIdx, expDist, (expDist == 10'd0));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_exact;
        test_pixel("white", 4'hE, 4'hE, 4'hE, 3'd0, 10'd0, LAT_WHITE);
        test_pixel("dup_a99", 4'hA, 4'h9, 4'h9, 3'd2, 10'd0, LAT_A99);
    endtask

    task automatic test_nearest;
        test_pixel("black", 4'h0, 4'h0, 4'h0, 3'd3, 10'd108, 8);
        test_pixel("full_white", 4'hF, 4'hF, 4'hF, 3'd0, 10'd3, 8);
    endtask

    task automatic test_backpressure;
        int lat;
        out_ready = 1'b0;
        send_pixel(4'hC, 4'hB, 4'hA);
        wait_result(lat);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            testsRun++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_index !== 3'd4 ||
                out_dist !== 10'd0 || out_exact !== 1'b1) begin
                testsFailed++;
                $display("[TB] FAIL hold_%0d: got valid=%b ready=%b idx=%0d dist=%0d exact=%b expected 1/0/4/0/1",
                         i, out_valid, in_ready, out_index, out_dist, out_exact);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        testsRun++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL hold_release: got ready=%b valid=%b expected 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid_search;
        int validSeen = 0;
        out_ready = 1'b1;
        send_pixel(4'h0, 4'h0, 4'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        testsRun++;
        if ({out_valid, out_index, out_dist, out_exact} !== 15'd0) begin
            testsFailed++;
            $display("[TB] FAIL mid_reset_outputs: got valid=%b idx=%0d dist=%0d exact=%b expected all 0",
                     out_valid, out_index, out_dist, out_exact);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) validSeen++;
        end
        testsRun++;
        if (validSeen !== 0) begin
            testsFailed++;
            $display("[TB] FAIL mid_reset_discard: got %0d valid cycles expected 0", validSeen);
        end
        test_pixel("after_reset", 4'hB, 4'hB, 4'hA, 3'd6, 10'd0, -1);
    endtask

    task automatic test_back_to_back;
        int acceptAt[2];
        logic [2:0] resIdx[2];
        logic [9:0] resDist[2];
        int acc = 0;
        int res = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 40 && res < 2; i++) begin
            @(negedge clk);
            in_valid = (acc < 2);
            if (acc == 0) {in_red, in_green, in_blue} = 12'h887;
            else          {in_red, in_green, in_blue} = 12'h111;
            if (out_valid && out_ready) begin
                resIdx[res]  = out_index;
                resDist[res] = out_dist;
                res++;
            end
            if (in_ready && in_valid) begin
                acceptAt[acc] = cycleCount;
                acc++;
            end
        end
        in_valid = 1'b0;
        testsRun++;
        if (res !== 2 || acc !== 2) begin
            testsFailed++;
            $display("[TB] FAIL b2b_count: got %0d results %0d accepts expected 2/2", res, acc);
        end else begin
            testsRun++;
            if (resIdx[0] !== 3'd7 || resDist[0] !== 10'd0) begin
                testsFailed++;
                $display("[TB] FAIL b2b_first: got idx=%0d dist=%0d expected 7/0", resIdx[0], resDist[0]);
            end
            testsRun++;
            if (resIdx[1] !== 3'd3 || resDist[1] !== 10'd75) begin
                testsFailed++;
                $display("[TB] FAIL b2b_second: got idx=%0d dist=%0d expected 3/75", resIdx[1], resDist[1]);
            end
            testsRun++;
            if (acceptAt[1] - acceptAt[0] !== 10) begin
                testsFailed++;
                $display("[TB] FAIL b2b_spacing: got %0d cycles expected 10", acceptAt[1] - acceptAt[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_exact();
        test_nearest();
        test_backpressure();
        test_reset_mid_search();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/game_palette_encoder.md
Name: game_palette_encoder

Overview:
- Reverse of the game's 8-entry palette lookup: takes a 12-bit RGB pixel and returns the 3-bit palette index of the nearest colour.
- Used when converting RGB tile/sprite art or framebuffer readback into index form for on-chip image ROMs.
- Iterative search, one palette entry per clock, with valid/ready handshakes on both input and output.

Parameters:
- N_ENTRIES, 8, number of palette entries searched; legal range 1..8, entries 0..N_ENTRIES-1 only.
- DIST_W, 10, width of the distance accumulator; holds a maximum distance of 3*15^2 = 675.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- in_valid  in  1  pixel presented.
- in_ready  out  1  encoder can accept a pixel.
- in_red  in  4  pixel red.
- in_green  in  4  pixel green.
- in_blue  in  4  pixel blue.
- out_valid  out  1  result presented.
- out_ready  in  1  consumer accepts result.
- out_index  out  3  nearest palette index.
- out_dist  out  DIST_W  squared distance to the chosen entry.
- out_exact  out  1  out_dist == 0.

Behaviour:
- Palette constants {R,G,B}, fixed internal table:
  - 0: E,E,E; 1: C,C,B; 2: A,9,9; 3: 6,6,6
  - 4: C,B,A; 5: A,9,9; 6: B,B,A; 7: 8,8,7
- Distance: dR^2 + dG^2 + dB^2.
  - Each difference is taken as an unsigned absolute value, 4 bits wide.
  - Each square is 8 bits; the sum is zero-extended to DIST_W.
- FSM states: IDLE, SEARCH, DONE.
  - IDLE: in_ready = 1. When in_valid is high, capture the RGB value, set best_dist to all-ones, best_idx = 0, cnt = 0, and go to SEARCH.
  - SEARCH: each cycle, evaluate entry cnt. Replace best only if dist < best_dist (strictly less), so ties keep the lowest index. If cnt == N_ENTRIES-1, go to DONE; otherwise cnt++.
  - DONE: out_valid = 1. out_index, out_dist and out_exact are registered and stay stable until out_ready is high. On out_valid && out_ready, go to IDLE.
- in_ready = (state == IDLE) && !Reset. There is no overlap between input and output transactions.
- Latency: out_valid rises N_ENTRIES cycles after the accepting edge (8 by default). Throughput is one pixel per N_ENTRIES + 2 cycles when out_ready is held high.
- Input RGB is sampled only at the accepting edge. Later changes on the input pins during SEARCH or DONE are ignored.
- Reset, from any state (including mid-SEARCH or DONE with out_valid pending):
  - state = IDLE, out_valid = 0, out_index = 0, out_dist = 0, out_exact = 0, cnt = 0.
  - Any pending result is discarded and is never presented.
- Identical entries: 2 and 5 are both A,9,9, so the pixel A,9,9 always returns 2.
- Backpressure in DONE is unbounded. Outputs hold and in_ready stays 0.

Optional Feature:
- Macro: GAME_PALETTE_ENCODER_EARLY_EXIT_EN.
- Defined: in SEARCH, if the evaluated entry has dist == 0, record it and go to DONE immediately. Latency becomes (matched index + 1) cycles. Tie rule is unchanged because entries are scanned from index 0 upward.
- Undefined: the full scan always runs, and latency is fixed at N_ENTRIES cycles regardless of match.

Test Plan:
- Pixel E,E,E, out_ready = 1 -> out_index = 0, out_dist = 0, out_exact = 1. out_valid appears 8 cycles after accept, or 1 cycle with EARLY_EXIT_EN.
- Pixel A,9,9 -> out_index = 2 (not 5), out_dist = 0, out_exact = 1. With EARLY_EXIT_EN, latency = 3.
- Pixel 0,0,0 -> out_index = 3, out_dist = 108, out_exact = 0. Pixel F,F,F -> out_index = 0, out_dist = 3.
- Pixel C,B,A accepted, then out_ready held 0 for 5 cycles after out_valid -> out_index = 4 and out_dist = 0 stay stable; in_ready = 0 throughout; release -> back to IDLE, in_ready = 1 the next cycle.
- Pixel 0,0,0 accepted, Reset pulsed 4 cycles later -> out_valid never asserts; all outputs = 0. A new pixel B,B,A after reset -> out_index = 6, out_dist = 0.
- Back-to-back: in_valid held high with pixels 8,8,7 then 1,1,1, out_ready = 1 -> results index 7 / dist 0, then index 3 / dist 75. Accepts are 10 cycles apart.
